// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter.
// - Load funct3 encodings (RISC-V I-type loads).
// - Load FIFO depth.
// - Packed writeback entry {rd, dat} used by the FIFO and the output mux.
package wb_arbiter_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int unsigned FIFO_DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_load_fmt.sv
// load_fmt: pure combinational load alignment and extension.
// Ports:
//   raw    - 32-bit word returned by memory
//   funct3 - load type (LB/LH/LW/LBU/LHU)
//   off    - byte offset of the access within the word
//   dat    - aligned, sign/zero-extended result
//   err    - misaligned access or illegal funct3
module load_fmt
  import wb_arbiter_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] dat,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (off)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = off[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    dat = '0;
    err = 1'b0;
    case (funct3)
      F3_LB:  dat = {{24{byte_sel[7]}}, byte_sel};
      F3_LH: begin
        dat = {{16{half_sel[15]}}, half_sel};
        err = off[0];
      end
      F3_LW: begin
        dat = raw;
        err = (off != 2'd0);
      end
      F3_LBU: dat = {24'd0, byte_sel};
      F3_LHU: begin
        dat = {16'd0, half_sel};
        err = off[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and load responses onto one registered
// register-file write port. ALU always wins; loads queue in a 2-entry FIFO
// and bypass it only when it is empty.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   alu_val/alu_rd/alu_dat      - ALU result (never back-pressured)
//   lsu_val/lsu_rd/lsu_raw/
//   lsu_funct3/lsu_off          - load response (raw word, type, offset)
//   lsu_rdy                     - load accepted when lsu_val & lsu_rdy
//   rd_val/rd/rd_dat            - registered register-file write port
//   alu_rd_val                  - current write comes from the ALU
//   lsu_err                     - one-cycle pulse for a dropped bad load
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_val,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_dat,
  input  logic        lsu_val,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_raw,
  input  logic [2:0]  lsu_funct3,
  input  logic [1:0]  lsu_off,
  output logic        lsu_rdy,
  output logic        rd_val,
  output logic [4:0]  rd,
  output logic [31:0] rd_dat,
  output logic        alu_rd_val,
  output logic        lsu_err
);

  wb_entry_t   fifo_mem [FIFO_DEPTH];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic [31:0] fmt_dat;
  logic        fmt_err;
  logic        accept;
  logic        good;
  wb_entry_t   lsu_entry;
  wb_entry_t   sel;
  logic        sel_valid;
  logic        sel_alu;
  logic        push;
  logic        pop;

  load_fmt u_load_fmt (
    .raw    (lsu_raw),
    .funct3 (lsu_funct3),
    .off    (lsu_off),
    .dat    (fmt_dat),
    .err    (fmt_err)
  );

  assign lsu_rdy   = (count < 2'(FIFO_DEPTH));
  assign accept    = lsu_val & lsu_rdy & ~rst;
  assign good      = accept & ~fmt_err;
  assign lsu_entry = '{rd: lsu_rd, dat: fmt_dat};

  // Priority: ALU > FIFO head > bypassed load. A good load that is not
  // itself selected is pushed, even when the head pops in the same cycle.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    sel_alu   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    if (alu_val) begin
      sel       = '{rd: alu_rd, dat: alu_dat};
      sel_valid = 1'b1;
      sel_alu   = 1'b1;
      push      = good;
    end else if (count != 2'd0) begin
      sel       = fifo_mem[rd_ptr];
      sel_valid = 1'b1;
      pop       = 1'b1;
      push      = good;
    end else if (good) begin
      sel       = lsu_entry;
      sel_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_ptr] <= lsu_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_val     <= 1'b0;
      alu_rd_val <= 1'b0;
      lsu_err    <= 1'b0;
      rd         <= '0;
      rd_dat     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= '0;
    end else begin
      // Writes to x0 are consumed but suppressed; rd/rd_dat keep last values.
      rd_val     <= sel_valid && (sel.rd != 5'd0);
      alu_rd_val <= sel_alu && (sel.rd != 5'd0);
      lsu_err    <= accept & fmt_err;
      if (sel_valid && (sel.rd != 5'd0)) begin
        rd     <= sel.rd;
        rd_dat <= sel.dat;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_val;
  logic [4:0]  alu_rd;
  logic [31:0] alu_dat;
  logic        lsu_val;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_raw;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_off;
  logic        lsu_rdy;
  logic        rd_val;
  logic [4:0]  rd;
  logic [31:0] rd_dat;
  logic        alu_rd_val;
  logic        lsu_err;

  int tests_run = 0;
  int failed    = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] dat;
  } ent_t;

  ent_t        q[$];
  logic        exp_val;
  logic        exp_alu;
  logic        exp_err;
  logic [4:0]  exp_rd;
  logic [31:0] exp_dat;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .alu_val    (alu_val),
    .alu_rd     (alu_rd),
    .alu_dat    (alu_dat),
    .lsu_val    (lsu_val),
    .lsu_rd     (lsu_rd),
    .lsu_raw    (lsu_raw),
    .lsu_funct3 (lsu_funct3),
    .lsu_off    (lsu_off),
    .lsu_rdy    (lsu_rdy),
    .rd_val     (rd_val),
    .rd         (rd),
    .rd_dat     (rd_dat),
    .alu_rd_val (alu_rd_val),
    .lsu_err    (lsu_err)
  );

  // Load formatting from the ISA definition, using arithmetic on values.
  function automatic void ref_fmt(input logic [31:0] raw, input logic [2:0] f3,
                                  input logic [1:0] off, output bit ok,
                                  output logic [31:0] v);
    int unsigned o, b, h;
    o  = int'(off);
    b  = (raw >> (8 * o)) & 32'hFF;
    h  = (raw >> (16 * (o / 2))) & 32'hFFFF;
    ok = 1'b1;
    v  = '0;
    case (f3)
      3'd0: v = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1: begin ok = (o % 2 == 0); v = (h >= 32768) ? h + 32'hFFFF_0000 : h; end
      3'd2: begin ok = (o == 0); v = raw; end
      3'd4: v = b;
      3'd5: begin ok = (o % 2 == 0); v = h; end
      default: ok = 1'b0;
    endcase
  endfunction

  // Advance the reference model by one cycle using the current inputs,
  // then clock the DUT and settle just after the edge.
  task automatic tick();
    bit          ok, acc, used, have, from_alu;
    logic [31:0] fv;
    ent_t        e;
    if (rst) begin
      q.delete();
      exp_val = 1'b0; exp_alu = 1'b0; exp_err = 1'b0;
      exp_rd  = '0;   exp_dat = '0;
    end else begin
      ref_fmt(lsu_raw, lsu_funct3, lsu_off, ok, fv);
      acc      = lsu_val && (q.size() < 2);
      have     = 1'b0;
      from_alu = 1'b0;
      used     = 1'b0;
      e        = '{5'd0, 32'd0};
      if (alu_val) begin
        have = 1'b1; from_alu = 1'b1; e = '{alu_rd, alu_dat};
      end else if (q.size() > 0) begin
        have = 1'b1; e = q.pop_front();
      end else if (acc && ok) begin
        have = 1'b1; used = 1'b1; e = '{lsu_rd, fv};
      end
      if (acc && ok && !used) q.push_back('{lsu_rd, fv});
      exp_err = acc && !ok;
      exp_val = have && (e.rd != 5'd0);
      exp_alu = exp_val && from_alu;
      if (exp_val) begin
        exp_rd  = e.rd;
        exp_dat = e.dat;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alu_val = 1'b0; alu_rd = '0; alu_dat = '0;
    lsu_val = 1'b0; lsu_rd = '0; lsu_raw = '0; lsu_funct3 = '0; lsu_off = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_val = 1'b1; alu_rd = 5'd9; alu_dat = 32'hDEAD_BEEF;
    lsu_val = 1'b1; lsu_rd = 5'd4; lsu_raw = 32'h1111_2222; lsu_funct3 = 3'd2;
    tick();
    tick();
    tests_run++;
    if (rd_val !== 1'b0 || alu_rd_val !== 1'b0 || lsu_err !== 1'b0) begin
      failed++;
      $display("FAIL reset_flags: rd_val=%b alu_rd_val=%b lsu_err=%b, want 0 0 0", rd_val, alu_rd_val, lsu_err);
    end
    tests_run++;
    if (rd !== 5'd0 || rd_dat !== 32'd0) begin
      failed++;
      $display("FAIL reset_port: rd=%0d rd_dat=%h, want 0 0", rd, rd_dat);
    end
    rst = 1'b0;
    set_idle();
    tests_run++;
    if (lsu_rdy !== 1'b1) begin
      failed++;
      $display("FAIL reset_rdy: lsu_rdy=%b, want 1", lsu_rdy);
    end
  endtask

  task automatic test_alu();
    alu_val = 1'b1; alu_rd = 5'd5; alu_dat = 32'h0000_1234;
    tick();
    set_idle();
    tests_run++;
    if (rd_val !== 1'b1 || rd !== 5'd5 || rd_dat !== 32'h1234 || alu_rd_val !== 1'b1) begin
      failed++;
      $display("FAIL alu_write: rd_val=%b rd=%0d rd_dat=%h alu_rd_val=%b, want 1 5 00001234 1",
               rd_val, rd, rd_dat, alu_rd_val);
    end
    tick();
    tests_run++;
    if (rd_val !== 1'b0 || rd !== 5'd5 || rd_dat !== 32'h1234) begin
      failed++;
      $display("FAIL alu_hold: rd_val=%b rd=%0d rd_dat=%h, want 0 5 00001234", rd_val, rd, rd_dat);
    end
  endtask

  task automatic test_lb();
    lsu_val = 1'b1; lsu_rd = 5'd3; lsu_raw = 32'h0080_FF00; lsu_funct3 = 3'd0; lsu_off = 2'd1;
    tests_run++;
    if (lsu_rdy !== 1'b1) begin
      failed++;
      $display("FAIL lb_rdy: lsu_rdy=%b, want 1", lsu_rdy);
    end
    tick();
    set_idle();
    tests_run++;
    if (rd_val !== 1'b1 || rd !== 5'd3 || rd_dat !== 32'hFFFF_FFFF || alu_rd_val !== 1'b0) begin
      failed++;
      $display("FAIL lb_bypass: rd_val=%b rd=%0d rd_dat=%h alu_rd_val=%b, want 1 3 ffffffff 0",
               rd_val, rd, rd_dat, alu_rd_val);
    end
  endtask

  task automatic test_contention();
    alu_val = 1'b1; alu_rd = 5'd1; alu_dat = 32'h0000_0001;
    lsu_val = 1'b1; lsu_rd = 5'd6; lsu_raw = 32'hA5A5_0006; lsu_funct3 = 3'd2; lsu_off = 2'd0;
    tick();
    alu_rd = 5'd2; alu_dat = 32'h2;
    lsu_rd = 5'd7; lsu_raw = 32'hA5A5_0007;
    tick();
    tests_run++;
    if (lsu_rdy !== 1'b0) begin
      failed++;
      $display("FAIL cont_full: lsu_rdy=%b, want 0", lsu_rdy);
    end
    alu_rd = 5'd3; alu_dat = 32'h3;
    lsu_rd = 5'd8; lsu_raw = 32'hA5A5_0008;
    tick();
    tests_run++;
    if (rd_val !== 1'b1 || rd !== 5'd3 || alu_rd_val !== 1'b1 || lsu_rdy !== 1'b0) begin
      failed++;
      $display("FAIL cont_alu3: rd_val=%b rd=%0d alu_rd_val=%b lsu_rdy=%b, want 1 3 1 0",
               rd_val, rd, alu_rd_val, lsu_rdy);
    end
    set_idle();
    tick();
    tests_run++;
    if (rd_val !== 1'b1 || rd !== 5'd6 || rd_dat !== 32'hA5A5_0006 || alu_rd_val !== 1'b0) begin
      failed++;
      $display("FAIL cont_first: rd_val=%b rd=%0d rd_dat=%h alu_rd_val=%b, want 1 6 a5a50006 0",
               rd_val, rd, rd_dat, alu_rd_val);
    end
    tick();
    tests_run++;
    if (rd_val !== 1'b1 || rd !== 5'd7 || rd_dat !== 32'hA5A5_0007) begin
      failed++;
      $display("FAIL cont_second: rd_val=%b rd=%0d rd_dat=%h, want 1 7 a5a50007", rd_val, rd, rd_dat);
    end
    tick();
    tests_run++;
    if (rd_val !== 1'b0 || rd !== 5'd7) begin
      failed++;
      $display("FAIL cont_blocked: rd_val=%b rd=%0d, want 0 7", rd_val, rd);
    end
  endtask

  task automatic test_err();
    lsu_val = 1'b1; lsu_rd = 5'd12; lsu_raw = 32'h1234_5678; lsu_funct3 = 3'd2; lsu_off = 2'd2;
    tests_run++;
    if (lsu_rdy !== 1'b1) begin
      failed++;
      $display("FAIL err_rdy: lsu_rdy=%b, want 1", lsu_rdy);
    end
    tick();
    set_idle();
    tests_run++;
    if (lsu_err !== 1'b1 || rd_val !== 1'b0) begin
      failed++;
      $display("FAIL err_pulse: lsu_err=%b rd_val=%b, want 1 0", lsu_err, rd_val);
    end
    tick();
    tests_run++;
    if (lsu_err !== 1'b0 || rd_val !== 1'b0) begin
      failed++;
      $display("FAIL err_end: lsu_err=%b rd_val=%b, want 0 0", lsu_err, rd_val);
    end
  endtask

  task automatic test_rd0();
    alu_val = 1'b1; alu_rd = 5'd0; alu_dat = 32'hCAFE_F00D;
    tick();
    set_idle();
    tests_run++;
    if (rd_val !== 1'b0 || alu_rd_val !== 1'b0 || rd_dat === 32'hCAFE_F00D) begin
      failed++;
      $display("FAIL rd0_alu: rd_val=%b alu_rd_val=%b rd_dat=%h, want 0 0 and rd_dat held",
               rd_val, alu_rd_val, rd_dat);
    end
  endtask

  task automatic test_reset_mid();
    alu_val = 1'b1; alu_rd = 5'd10; alu_dat = 32'h10;
    lsu_val = 1'b1; lsu_rd = 5'd20; lsu_raw = 32'h20; lsu_funct3 = 3'd2; lsu_off = 2'd0;
    tick();
    lsu_rd = 5'd21;
    tick();
    tests_run++;
    if (lsu_rdy !== 1'b0) begin
      failed++;
      $display("FAIL mid_full: lsu_rdy=%b, want 0", lsu_rdy);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (rd_val !== 1'b0 || lsu_rdy !== 1'b1) begin
      failed++;
      $display("FAIL mid_reset: rd_val=%b lsu_rdy=%b, want 0 1", rd_val, lsu_rdy);
    end
    rst = 1'b0;
    set_idle();
    tick();
    tests_run++;
    if (rd_val !== 1'b0 || lsu_rdy !== 1'b1) begin
      failed++;
      $display("FAIL mid_discard: rd_val=%b lsu_rdy=%b, want 0 1", rd_val, lsu_rdy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 79) == 0);
      alu_val    = ($urandom_range(0, 2) == 0);
      alu_rd     = 5'($urandom_range(0, 31));
      alu_dat    = $urandom;
      lsu_val    = ($urandom_range(0, 1) == 0);
      lsu_rd     = 5'($urandom_range(0, 31));
      lsu_raw    = $urandom;
      lsu_funct3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                               : ((($urandom_range(0, 1) == 0)) ? 3'd0 : 3'd5);
      if ($urandom_range(0, 2) == 0) lsu_funct3 = 3'd2;
      lsu_off    = 2'($urandom_range(0, 3));
      tick();
      tests_run++;
      if (rd_val !== exp_val || alu_rd_val !== exp_alu || lsu_err !== exp_err) begin
        failed++;
        $display("FAIL rand_flags[%0d]: rd_val=%b alu_rd_val=%b lsu_err=%b, want %b %b %b",
                 i, rd_val, alu_rd_val, lsu_err, exp_val, exp_alu, exp_err);
      end
      tests_run++;
      if (rd !== exp_rd || rd_dat !== exp_dat) begin
        failed++;
        $display("FAIL rand_port[%0d]: rd=%0d rd_dat=%h, want %0d %h", i, rd, rd_dat, exp_rd, exp_dat);
      end
      tests_run++;
      if (lsu_rdy !== (q.size() < 2)) begin
        failed++;
        $display("FAIL rand_rdy[%0d]: lsu_rdy=%b, want %b", i, lsu_rdy, (q.size() < 2));
      end
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_alu();
    test_lb();
    test_contention();
    test_err();
    test_rd0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: alu_val / alu_rd[4:0] / alu_dat[31:0]  in  ALU result; no back-pressure, must be accepted every cycle.
REQ-004 SHALL have: lsu_val / lsu_rd[4:0] / lsu_raw[31:0] / lsu_funct3[2:0] / lsu_off[1:0]  in  load response: raw word, load type, byte offset.
REQ-005 SHALL have: lsu_rdy  out  1  load accepted when lsu_val & lsu_rdy.
REQ-006 SHALL have: rd_val / rd[4:0] / rd_dat[31:0]  out  registered register-file write port.
REQ-007 SHALL have: alu_rd_val  out  1  current write originates from ALU path, for register-file hazard stall.
REQ-008 SHALL have: lsu_err  out  1  one-cycle pulse, misaligned or illegal load dropped.

Function
REQ-009 SHALL contain 2-entry load FIFO holding formatted {rd, dat}; lsu_rdy = (count < 2), combinational from registered count.
REQ-010 SHALL, per cycle, load output register by priority: alu_val > FIFO head > accepted LSU input (bypass when FIFO empty) > idle.
REQ-011 SHALL give ALU latency exactly 1 cycle; uncontended load latency exactly 1 cycle.
REQ-012 SHALL push an accepted load into FIFO when it is not selected; push and pop in the same cycle keep count unchanged.
REQ-013 SHALL keep FIFO order strict; a load bypasses only when FIFO empty.
REQ-014 SHALL format loads: 000 LB sign-ext byte at off; 001 LH sign-ext half at off[1]; 010 LW; 100 LBU; 101 LHU zero-ext.
REQ-015 SHALL treat LH/LHU with off[0]=1, LW with off!=0, or funct3 in {011,110,111} as error: accept (consume handshake), not enqueue, pulse lsu_err next cycle.
REQ-016 SHALL drive rd_val=0 for any selected entry with rd==0; entry still consumed.
REQ-017 SHALL set alu_rd_val=1 only when rd_val=1 and source was ALU; 0 for load writes.
REQ-018 SHALL hold rd and rd_dat at last values when rd_val=0.
REQ-019 SHALL not drop or duplicate any accepted load under continuous alu_val.

Reset
REQ-020 SHALL, while rst=1: rd_val=0, alu_rd_val=0, lsu_err=0, rd=0, rd_dat=0, FIFO count=0, pointers=0.
REQ-021 SHALL discard FIFO contents and in-flight input on reset mid-operation; lsu_rdy=1 first cycle after rst deasserts.
REQ-022 SHALL ignore alu_val/lsu_val in reset cycles.

Structure
REQ-023 SHALL place load funct3 encodings and FIFO depth constant in shared core package.
REQ-024 SHALL implement load alignment/extension as sub-module load_fmt (pure combinational).
REQ-025 SHALL implement FIFO inline with 1-bit pointers and 2-bit count.

Verification
REQ-026 SHALL test: alu_val=1, alu_rd=5, alu_dat=0x1234 -> next cycle rd_val=1, rd=5, rd_dat=0x1234, alu_rd_val=1.
REQ-027 SHALL test: lsu LB rd=3, raw=0x0080FF00, off=1, FIFO empty, no ALU -> next cycle rd=3, rd_dat=0xFFFFFFFF, alu_rd_val=0.
REQ-028 SHALL test: alu_val held 3 cycles, loads rd=6,7 offered -> both enqueued, third blocked (lsu_rdy=0); rd=6 then rd=7 written after ALU stops.
REQ-029 SHALL test: LW off=2 -> accepted, lsu_err=1 one cycle, rd_val=0.
REQ-030 SHALL test: alu_rd=0 alu_val=1 -> rd_val=0, alu_rd_val=0.
REQ-031 SHALL test: rst=1 with FIFO count=2 -> next cycle count=0, rd_val=0, lsu_rdy=1 after release.
